if_id_queue: RTL and testbench

Instruction queue between the instruction-fetch stage and the decode stage of the 64-bit RISC-V pipeline. It accepts one fetched {PC, PC+4, instruction} triple per cycle under a valid/ready handshake. It holds up to DEPTH entries in a circular buffer and presents the oldest entry to decode. A synchronous flush discards all entries on a branch or jump redirect. When the queue is empty, decode sees a canonical NOP bubble.

---
 rtl/core_pkg.sv | 16 +
 rtl/if_id_queue.sv | 97 +++++++++
 tb/tb_if_id_queue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared pipeline types and constants for the 64-bit RISC-V core.
package core_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  // addi x0,x0,0: the canonical bubble decode sees when the queue is empty
  localparam logic [ILEN-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of DEPTH {pc, pc4, inst}
// entries with valid/ready on both sides and a synchronous redirect flush.
module if_id_queue
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_pc4,
  input  logic [ILEN-1:0]            in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc4,
  output logic [ILEN-1:0]            out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_in_entry;
  fetch_entry_t w_head;

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);

  // No full-bypass: a pop while full does not open in_ready until next cycle.
  assign in_ready  = !w_full && !flush;
  assign out_valid = !w_empty;

  assign w_push = in_valid && in_ready;
  // Flush ignores out_ready; the pointers are reset instead of advanced.
  assign w_pop  = out_valid && out_ready && !flush;

  assign w_in_entry = '{pc: in_pc, pc4: in_pc4, inst: in_inst};

  // Storage is data only and needs no reset; valid-ness comes from r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // Pointer and occupancy update; flush dominates push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation: oldest entry, or a NOP bubble with zeroed PCs when empty.
  always_comb begin
    w_head = r_mem[r_rd_ptr];
    if (w_empty) begin
      w_head = '{pc: '0, pc4: '0, inst: NOP_INST};
    end
  end

  assign out_pc   = w_head.pc;
  assign out_pc4  = w_head.pc4;
  assign out_inst = w_head.inst;
  assign count    = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a vector table of per-cycle stimulus with the
// expected pre-edge outputs, plus a scoreboard stream and an async-reset sequence.
module tb_if_id_queue;
  import core_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_pc4;
  logic [ILEN-1:0]   in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_pc4;
  logic [ILEN-1:0]   out_inst;
  logic [$clog2(DEPTH):0] count;

  int n_cmp;
  int n_fail;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_pc4    (in_pc4),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_inst  (out_inst),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [63:0] pc;
    logic        ordy;
    int          exp_cnt;
    logic        exp_ov;
    logic        exp_ir;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  // Instruction word tagged with its PC so a misplaced entry shows up in out_inst too.
  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return 32'hA000_0000 | pc[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [63:0] pc, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_pc4    = pc + 64'd4;
    in_inst   = inst_of(pc);
    out_ready = ordy;
  endtask

  // Compare all outputs against the expected state before the coming edge.
  task automatic check_outputs(input string tag, input int exp_cnt, input logic exp_ov,
                               input logic exp_ir, input logic [63:0] exp_pc);
    check({tag, ".count"},     64'(count),     64'(exp_cnt));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
    check({tag, ".in_ready"},  64'(in_ready),  64'(exp_ir));
    check({tag, ".out_pc"},    out_pc,         exp_ov ? exp_pc : 64'd0);
    check({tag, ".out_pc4"},   out_pc4,        exp_ov ? exp_pc + 64'd4 : 64'd0);
    check({tag, ".out_inst"},  64'(out_inst),  64'(exp_ov ? inst_of(exp_pc) : NOP_INST));
  endtask

  task automatic add(input logic fl, input logic iv, input logic [63:0] pc, input logic ordy,
                     input int ec, input logic eov, input logic eir, input logic [63:0] epc);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.exp_cnt = ec; v.exp_ov = eov; v.exp_ir = eir; v.exp_pc = epc;
    vecs.push_back(v);
  endtask

  logic [63:0] sb[$];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 1'b0);

    //   fl iv pc       ordy | count ov  ir  head pc
    add(0, 0, 64'h00, 0,   0, 0, 1, 64'h00);  // reset state
    add(0, 1, 64'h00, 0,   0, 0, 1, 64'h00);
    add(0, 1, 64'h04, 0,   1, 1, 1, 64'h00);
    add(0, 1, 64'h08, 0,   2, 1, 1, 64'h00);
    add(0, 0, 64'h00, 1,   3, 1, 1, 64'h00);
    add(0, 0, 64'h00, 1,   2, 1, 1, 64'h04);
    add(0, 0, 64'h00, 1,   1, 1, 1, 64'h08);
    add(0, 0, 64'h00, 0,   0, 0, 1, 64'h00);  // drained: NOP bubble
    add(0, 1, 64'h10, 0,   0, 0, 1, 64'h00);  // fill across the pointer wrap
    add(0, 1, 64'h14, 0,   1, 1, 1, 64'h10);
    add(0, 1, 64'h18, 0,   2, 1, 1, 64'h10);
    add(0, 1, 64'h1c, 0,   3, 1, 1, 64'h10);
    add(0, 1, 64'h20, 0,   4, 1, 0, 64'h10);  // full: 5th push refused
    add(0, 1, 64'h20, 1,   4, 1, 0, 64'h10);  // pop while full, still no push
    add(0, 0, 64'h00, 0,   3, 1, 1, 64'h14);  // in_ready back one cycle later
    add(0, 0, 64'h00, 1,   3, 1, 1, 64'h14);
    for (int i = 0; i < 10; i++) begin       // streaming at count 2
      add(0, 1, 64'h24 + 64'(4 * i), 1, 2, 1, 1, (i < 2) ? 64'h18 + 64'(4 * i)
                                                        : 64'h24 + 64'(4 * (i - 2)));
    end
    add(0, 1, 64'h4c, 0,   2, 1, 1, 64'h44);
    add(1, 1, 64'h50, 1,   3, 1, 0, 64'h44);  // flush with push and pop requested
    add(0, 0, 64'h00, 0,   0, 0, 1, 64'h00);
    add(0, 1, 64'h60, 0,   0, 0, 1, 64'h00);
    add(0, 0, 64'h00, 0,   1, 1, 1, 64'h60);  // flushed 0x50 never surfaced

    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      #2;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_ov,
                    vecs[i].exp_ir, vecs[i].exp_pc);
      @(posedge clk);
      #1;
    end

    // Scoreboard stream with irregular push/pop, starting from the 0x60 entry.
    sb.push_back(64'h60);
    for (int i = 0; i < 24; i++) begin
      logic iv;
      logic ordy;
      logic [63:0] pc;
      bit do_push;
      bit do_pop;
      iv   = (i % 3 != 2);
      ordy = (i % 4 != 0);
      pc   = 64'h100 + 64'(4 * i);
      drive(1'b0, iv, pc, ordy);
      #2;
      check_outputs($sformatf("sb%0d", i), sb.size(), sb.size() != 0,
                    sb.size() < DEPTH, (sb.size() != 0) ? sb[0] : 64'd0);
      do_push = iv && (sb.size() < DEPTH);
      do_pop  = ordy && (sb.size() != 0);
      @(posedge clk);
      #1;
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(pc);
    end

    // Bring occupancy to exactly two, then assert reset mid-cycle.
    drive(1'b0, 1'b0, 64'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b1, 64'h200, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 64'h204, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 64'd0, 1'b0);
    #1;
    check_outputs("pre_rst", 2, 1'b1, 1'b1, 64'h200);
    #1;
    reset = 1'b1;
    #1;
    check_outputs("async_rst", 0, 1'b0, 1'b1, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b1, 64'h20, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 64'd0, 1'b0);
    #1;
    check_outputs("post_rst", 1, 1'b1, 1'b1, 64'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Backstop so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
